// File: rtl/mandelbrot_pass_sched_pkg.sv
// mandelbrot_pass_sched_pkg: shared types and word layout for the frame pass scheduler
package mandelbrot_pass_sched_pkg;
    localparam int WORD_W = 104;
    localparam int PXVAL_LSB = 96;
    typedef enum logic [1:0] {S_IDLE, S_PASS, S_DRAIN, S_DONE} state_t;
    // Pixel-state word, MSB first: PXVAL 103:96, X 95:64, Y 63:32, ITER 31:0
    typedef struct packed {
        logic [7:0]  pxval;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] iter;
    } word_t;
endpackage

// File: rtl/mandelbrot_pass_sched_skid_fifo.sv
// mandelbrot_pass_sched_skid_fifo: show-ahead buffer holding in-order state-read data
module mandelbrot_pass_sched_skid_fifo
    import mandelbrot_pass_sched_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_n,
    input  logic                    push,
    input  logic [WORD_W-1:0]       wdata,
    input  logic                    pop,
    output logic [WORD_W-1:0]       rdata,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign rdata = mem[rd_ptr];
    always_ff @(posedge i_Clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/mandelbrot_pass_sched.sv
// mandelbrot_pass_sched: streams every pixel word through the math FIFOs for MAX_ITER passes per frame
module mandelbrot_pass_sched
    import mandelbrot_pass_sched_pkg::*;
#(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 480,
    parameter int MAX_ITER   = 64,
    parameter int ADDR_W     = 19,
    parameter int RD_CREDITS = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Start,
    input  logic [1:0]        i_Draw,
    output logic [1:0]        o_Draw,
    output logic              o_Busy,
    output logic              o_Frame_Done,
    output logic [7:0]        o_Pass,
    output logic [WORD_W-1:0] o_Feed_Data,
    output logic              o_Feed_Wrreq,
    input  logic              i_Feed_Full,
    input  logic [WORD_W-1:0] i_Ret_Data,
    input  logic              i_Ret_Empty,
    output logic              o_Ret_Ack,
    output logic              o_Mem_Rd_Req,
    output logic [ADDR_W-1:0] o_Mem_Rd_Addr,
    input  logic              i_Mem_Rd_Ready,
    input  logic              i_Mem_Rd_Valid,
    input  logic [WORD_W-1:0] i_Mem_Rd_Data,
    output logic              o_Mem_Wr_Req,
    output logic [ADDR_W-1:0] o_Mem_Wr_Addr,
    output logic [WORD_W-1:0] o_Mem_Wr_Data,
    input  logic              i_Mem_Wr_Ready,
    output logic              o_Fb_Wr,
    output logic [ADDR_W-1:0] o_Fb_Addr,
    output logic [7:0]        o_Fb_Data,
    input  logic              i_Fb_Ready
);
    localparam int N  = H_ACTIVE * V_ACTIVE;
    localparam int CW = ADDR_W + 1;
    localparam int KW = $clog2(RD_CREDITS) + 1;
    state_t state;
    logic [CW-1:0] rd_cnt, feed_cnt, ret_cnt, feed_nxt, ret_nxt;
    logic [KW-1:0] inflight, skid_cnt;
    logic [WORD_W-1:0] skid_head;
    logic first, last, moving, feed_wr, rd_fire, ret_ok, ret_ack;
    assign first    = o_Pass == 8'd0;
    assign last     = o_Pass == 8'(MAX_ITER - 1);
    assign moving   = state == S_PASS || state == S_DRAIN;
    assign feed_wr  = state == S_PASS && feed_cnt < CW'(N) && !i_Feed_Full && (first || skid_cnt != '0);
    // Credits cover both requests in flight and words already parked in the skid FIFO
    assign o_Mem_Rd_Req  = state == S_PASS && !first && rd_cnt < CW'(N)
                           && (KW+1)'(inflight) + (KW+1)'(skid_cnt) < (KW+1)'(RD_CREDITS);
    assign rd_fire       = o_Mem_Rd_Req && i_Mem_Rd_Ready;
    assign o_Mem_Rd_Addr = o_Mem_Rd_Req ? rd_cnt[ADDR_W-1:0] : '0;
    assign o_Feed_Wrreq  = feed_wr;
    assign o_Feed_Data   = feed_wr && !first ? skid_head : '0;
    assign ret_ok        = moving && !i_Ret_Empty && ret_cnt < CW'(N);
    assign ret_ack       = ret_ok && (last ? i_Fb_Ready : i_Mem_Wr_Ready);
    assign o_Ret_Ack     = ret_ack;
    assign o_Mem_Wr_Req  = ret_ok && !last;
    assign o_Mem_Wr_Addr = o_Mem_Wr_Req ? ret_cnt[ADDR_W-1:0] : '0;
    assign o_Mem_Wr_Data = o_Mem_Wr_Req ? i_Ret_Data : '0;
    assign o_Fb_Wr       = ret_ok && last;
    assign o_Fb_Addr     = o_Fb_Wr ? ret_cnt[ADDR_W-1:0] : '0;
    assign o_Fb_Data     = o_Fb_Wr ? i_Ret_Data[PXVAL_LSB +: 8] : '0;
    assign feed_nxt      = feed_cnt + CW'(feed_wr);
    assign ret_nxt       = ret_cnt + CW'(ret_ack);
    mandelbrot_pass_sched_skid_fifo #(.DEPTH(RD_CREDITS)) u_skid (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .push    (i_Mem_Rd_Valid),
        .wdata   (i_Mem_Rd_Data),
        .pop     (feed_wr && !first),
        .rdata   (skid_head),
        .count   (skid_cnt)
    );
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state        <= S_IDLE;
            o_Draw       <= '0;
            o_Pass       <= '0;
            o_Busy       <= 1'b0;
            o_Frame_Done <= 1'b0;
            rd_cnt       <= '0;
            feed_cnt     <= '0;
            ret_cnt      <= '0;
            inflight     <= '0;
        end else begin
            rd_cnt       <= rd_cnt + CW'(rd_fire);
            feed_cnt     <= feed_nxt;
            ret_cnt      <= ret_nxt;
            inflight     <= inflight + KW'(rd_fire) - KW'(i_Mem_Rd_Valid);
            o_Frame_Done <= 1'b0;
            case (state)
                S_IDLE: if (i_Start) begin
                    state    <= S_PASS;
                    o_Busy   <= 1'b1;
                    o_Draw   <= i_Draw;
                    o_Pass   <= '0;
                    rd_cnt   <= '0;
                    feed_cnt <= '0;
                    ret_cnt  <= '0;
                end
                S_PASS: if (feed_nxt == CW'(N)) state <= S_DRAIN;
                // Next pass starts only after the last write of this one is accepted
                S_DRAIN: if (ret_nxt == CW'(N)) begin
                    if (last) begin
                        state        <= S_DONE;
                        o_Frame_Done <= 1'b1;
                    end else begin
                        state    <= S_PASS;
                        o_Pass   <= o_Pass + 8'd1;
                        rd_cnt   <= '0;
                        feed_cnt <= '0;
                        ret_cnt  <= '0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mandelbrot_pass_sched.sv
// tb_mandelbrot_pass_sched: frame-level checks against math, state-memory and framebuffer models
module tb_mandelbrot_pass_sched;
    localparam int H = 4, V = 2, MI = 3, AW = 3, RC = 4, N = H * V;
    logic i_Clk = 0, i_Rst_n = 0, i_Start = 0;
    logic [1:0] i_Draw = 0, o_Draw;
    logic o_Busy, o_Frame_Done, o_Feed_Wrreq, o_Ret_Ack, o_Mem_Rd_Req, o_Mem_Wr_Req, o_Fb_Wr;
    logic [7:0] o_Pass, o_Fb_Data;
    logic [103:0] o_Feed_Data, o_Mem_Wr_Data;
    logic [AW-1:0] o_Mem_Rd_Addr, o_Mem_Wr_Addr, o_Fb_Addr;
    logic i_Feed_Full = 0, i_Ret_Empty = 1, i_Mem_Rd_Ready = 0, i_Mem_Rd_Valid = 0, i_Mem_Wr_Ready = 0, i_Fb_Ready = 0;
    logic [103:0] i_Ret_Data = 0, i_Mem_Rd_Data = 0;

    mandelbrot_pass_sched #(.H_ACTIVE(H), .V_ACTIVE(V), .MAX_ITER(MI), .ADDR_W(AW), .RD_CREDITS(RC)) dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Start(i_Start), .i_Draw(i_Draw), .o_Draw(o_Draw),
        .o_Busy(o_Busy), .o_Frame_Done(o_Frame_Done), .o_Pass(o_Pass),
        .o_Feed_Data(o_Feed_Data), .o_Feed_Wrreq(o_Feed_Wrreq), .i_Feed_Full(i_Feed_Full),
        .i_Ret_Data(i_Ret_Data), .i_Ret_Empty(i_Ret_Empty), .o_Ret_Ack(o_Ret_Ack),
        .o_Mem_Rd_Req(o_Mem_Rd_Req), .o_Mem_Rd_Addr(o_Mem_Rd_Addr), .i_Mem_Rd_Ready(i_Mem_Rd_Ready),
        .i_Mem_Rd_Valid(i_Mem_Rd_Valid), .i_Mem_Rd_Data(i_Mem_Rd_Data),
        .o_Mem_Wr_Req(o_Mem_Wr_Req), .o_Mem_Wr_Addr(o_Mem_Wr_Addr), .o_Mem_Wr_Data(o_Mem_Wr_Data),
        .i_Mem_Wr_Ready(i_Mem_Wr_Ready), .o_Fb_Wr(o_Fb_Wr), .o_Fb_Addr(o_Fb_Addr), .o_Fb_Data(o_Fb_Data),
        .i_Fb_Ready(i_Fb_Ready)
    );

    always #5 i_Clk = ~i_Clk;

    int vec_n = 0, miss_n = 0;
    int feed_stall_pct = 0, wr_rdy_pct = 100, rd_rdy_pct = 100, fb_rdy_pct = 100;
    bit force_full = 0;
    int feed_n, rd_n, wr_n, fb_n, done_n, max_out, cyc = 0, k = 0;
    time wr_done_t[4], rd_first_t[4];
    logic [103:0] smem [N];
    logic [103:0] min_q[$], out_q[$];
    typedef struct {logic [103:0] d; int due;} rd_t;
    rd_t rd_pipe[$];
    typedef struct {
        logic [1:0] draw;
        int fstall, wrdy, rrdy, frdy;
        logic [1:0] exp_draw;
        int exp_feeds, exp_wrs, exp_fbs;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vec_n++;
        if (act !== exp) begin
            miss_n++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // State word after pass p at pixel a: the math model adds (a+1) to PXVAL every pass
    function automatic logic [103:0] exp_word(input int p, input int a);
        return {8'((p + 1) * (a + 1)), 32'(a), 32'd0, 32'(p + 1)};
    endfunction

    function automatic logic [255:0] outs();
        return {o_Draw, o_Busy, o_Frame_Done, o_Pass, o_Feed_Data, o_Feed_Wrreq, o_Ret_Ack, o_Mem_Rd_Req,
                o_Mem_Rd_Addr, o_Mem_Wr_Req, o_Mem_Wr_Addr, o_Mem_Wr_Data, o_Fb_Wr, o_Fb_Addr, o_Fb_Data};
    endfunction

    task automatic clear_sb();
        feed_n = 0; rd_n = 0; wr_n = 0; fb_n = 0; done_n = 0; max_out = 0;
        for (int i = 0; i < 4; i++) begin
            wr_done_t[i] = 0;
            rd_first_t[i] = 0;
        end
    endtask

    task automatic cycle();
        @(posedge i_Clk);
        #2;
    endtask

    task automatic start_frame(input logic [1:0] d);
        cycle();
        i_Draw = d;
        i_Start = 1;
        cycle();
        i_Start = 0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (done_n == 0 && i < budget) begin
            cycle();
            i++;
        end
        chk("frame_timeout", done_n != 0, 1);
        repeat (3) cycle();
    endtask

    task automatic wait_pass(input logic [7:0] p);
        int i = 0;
        while (o_Pass != p && i < 2000) begin
            cycle();
            i++;
        end
        chk("reach_pass", o_Pass, p);
    endtask

    task automatic chk_totals(input string name, input logic [1:0] d);
        chk(name, {feed_n, rd_n, wr_n, fb_n, done_n, o_Busy, o_Draw},
            {32'(N * MI), 32'(N * (MI - 1)), 32'(N * (MI - 1)), 32'(N), 32'd1, 1'b0, d});
    endtask

    // Environment: observe at negedge, then update models and drive inputs just after posedge
    initial begin : env
        logic c_feed, c_rd, c_wr, c_fb, c_ack, c_valid;
        logic [103:0] c_fd, c_wd, w;
        logic [AW-1:0] c_ra, c_wa, c_fa;
        logic [7:0] c_fbd;
        int outst;
        forever begin
            @(negedge i_Clk);
            c_feed = o_Feed_Wrreq; c_fd = o_Feed_Data;
            c_rd = o_Mem_Rd_Req && i_Mem_Rd_Ready; c_ra = o_Mem_Rd_Addr;
            c_wr = o_Mem_Wr_Req && i_Mem_Wr_Ready; c_wa = o_Mem_Wr_Addr; c_wd = o_Mem_Wr_Data;
            c_fb = o_Fb_Wr && i_Fb_Ready; c_fa = o_Fb_Addr; c_fbd = o_Fb_Data;
            c_ack = o_Ret_Ack; c_valid = i_Mem_Rd_Valid;
            if (c_feed) begin
                chk("feed_word", {1'(feed_n < N * MI), c_fd},
                    {1'b1, feed_n < N ? 104'd0 : exp_word(feed_n / N - 1, feed_n % N)});
                feed_n++;
            end
            if (c_rd) begin
                chk("rd_order", {c_ra, 1'(wr_n >= N * (rd_n / N + 1))}, {AW'(rd_n % N), 1'b1});
                if (rd_n % N == 0 && rd_n / N + 1 < 4) rd_first_t[rd_n / N + 1] = $time;
                rd_n++;
                outst = rd_n - (feed_n > N ? feed_n - N : 0);
                if (outst > max_out) max_out = outst;
                chk("credits", outst <= RC, 1);
            end
            if (c_wr) begin
                chk("state_wr", {c_wa, c_wd, o_Pass}, {AW'(wr_n % N), exp_word(wr_n / N, wr_n % N), 8'(wr_n / N)});
                wr_n++;
                if (wr_n % N == 0 && wr_n / N <= 4) wr_done_t[wr_n / N - 1] = $time;
            end
            if (c_fb) begin
                chk("fb_wr", {c_fa, c_fbd, 1'(wr_n == N * (MI - 1))}, {AW'(fb_n % N), 8'(MI * (fb_n % N + 1)), 1'b1});
                fb_n++;
            end
            if (o_Frame_Done) done_n++;
            @(posedge i_Clk);
            #1;
            if (!i_Rst_n) begin
                min_q.delete();
                out_q.delete();
                rd_pipe.delete();
                k = 0;
            end else begin
                if (c_ack) void'(out_q.pop_front());
                if (c_wr) smem[c_wa] = c_wd;
                if (c_valid) void'(rd_pipe.pop_front());
                if (min_q.size() > 0) begin
                    w = min_q.pop_front();
                    out_q.push_back({w[103:96] + 8'(k + 1), 32'(k), w[63:32], w[31:0] + 32'd1});
                    k = (k + 1) % N;
                end
                if (c_feed) min_q.push_back(c_fd);
                if (c_rd) rd_pipe.push_back('{smem[c_ra], cyc + 2});
            end
            cyc++;
            i_Ret_Empty = out_q.size() == 0;
            i_Ret_Data = out_q.size() > 0 ? out_q[0] : 104'd0;
            i_Feed_Full = force_full || min_q.size() >= 4 || $urandom_range(99) < feed_stall_pct;
            i_Mem_Rd_Valid = rd_pipe.size() > 0 && rd_pipe[0].due <= cyc;
            i_Mem_Rd_Data = i_Mem_Rd_Valid ? rd_pipe[0].d : 104'd0;
            i_Mem_Rd_Ready = $urandom_range(99) < rd_rdy_pct;
            i_Mem_Wr_Ready = $urandom_range(99) < wr_rdy_pct;
            i_Fb_Ready = $urandom_range(99) < fb_rdy_pct;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'd0, 0, 100, 100, 100, 2'd0, N * MI, N * (MI - 1), N};
        tbl[1] = '{2'd1, 30, 60, 70, 50, 2'd1, N * MI, N * (MI - 1), N};
        tbl[2] = '{2'd2, 50, 40, 50, 30, 2'd2, N * MI, N * (MI - 1), N};
        tbl[3] = '{2'd3, 70, 80, 30, 90, 2'd3, N * MI, N * (MI - 1), N};
        tbl[4] = '{2'd0, 20, 90, 100, 40, 2'd0, N * MI, N * (MI - 1), N};
        repeat (3) cycle();
        chk("reset_outs", outs(), 0);
        i_Rst_n = 1;
        cycle();
        chk("idle_outs", outs(), 0);
        for (int r = 0; r < 5; r++) begin
            feed_stall_pct = tbl[r].fstall; wr_rdy_pct = tbl[r].wrdy;
            rd_rdy_pct = tbl[r].rrdy; fb_rdy_pct = tbl[r].frdy;
            clear_sb();
            start_frame(tbl[r].draw);
            chk("busy_after_start", {o_Busy, o_Pass, o_Draw}, {1'b1, 8'd0, tbl[r].exp_draw});
            wait_done(4000);
            chk("frame_totals", {feed_n, rd_n, wr_n, fb_n, done_n, o_Busy, o_Draw},
                {32'(tbl[r].exp_feeds), 32'(tbl[r].exp_feeds - N), 32'(tbl[r].exp_wrs),
                 32'(tbl[r].exp_fbs), 32'd1, 1'b0, tbl[r].exp_draw});
        end
        feed_stall_pct = 0; wr_rdy_pct = 25; rd_rdy_pct = 100; fb_rdy_pct = 100;
        clear_sb();
        start_frame(2'd0);
        wait_done(4000);
        chk("pass_order", {1'(rd_first_t[1] > wr_done_t[0]), 1'(rd_first_t[2] > wr_done_t[1]), 1'(wr_done_t[1] != 0)}, 3'b111);
        wr_rdy_pct = 100;
        clear_sb();
        start_frame(2'd3);
        wait_pass(8'd1);
        force_full = 1;
        repeat (12) cycle();
        chk("credit_stall", {o_Mem_Rd_Req, o_Feed_Wrreq, max_out}, {1'b0, 1'b0, 32'(RC)});
        force_full = 0;
        wait_done(4000);
        chk_totals("credit_frame", 2'd3);
        feed_stall_pct = 20; wr_rdy_pct = 70; fb_rdy_pct = 70;
        clear_sb();
        start_frame(2'd1);
        repeat (10) cycle();
        i_Draw = 2'd2;
        i_Start = 1;
        cycle();
        i_Start = 0;
        chk("draw_hold", {o_Draw, o_Busy}, {2'd1, 1'b1});
        wait_done(4000);
        chk_totals("ignored_start_frame", 2'd1);
        clear_sb();
        start_frame(2'd2);
        wait_pass(8'd1);
        repeat (3) cycle();
        i_Rst_n = 0;
        #1;
        chk("async_reset", outs(), 0);
        repeat (3) cycle();
        i_Rst_n = 1;
        cycle();
        clear_sb();
        start_frame(2'd2);
        wait_done(4000);
        chk_totals("post_reset_frame", 2'd2);
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end
endmodule
